sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO with the same buffering role as the team's fixed 8×8 FIFO, generalised in data width and depth. It accepts simultaneous read and write in one cycle and exposes full/empty/occupancy status plus a registered read-valid strobe. It sits between a producer and a consumer in one clock domain.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full threshold (entries)
- AE_LEVEL, 1, almost_empty threshold (entries)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wen  in  1  write request
- ren  in  1  read request
- din  in  WIDTH  write data
- dout  out  WIDTH  read data, registered
- valid  out  1  dout carries data from an accepted read this cycle
- error  out  1  previous cycle's request was rejected
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL

## Operation
- Pointers: $clog2(DEPTH)+1 bits each (wrap bit plus address). Address = low bits. Increment wraps naturally modulo 2·DEPTH.
- Read accepted iff ren && !empty. Effects: dout <= mem[rd_ptr], valid <= 1, rd_ptr++.
- Write accepted iff wen && (!full || read accepted the same cycle). Effects: mem[wr_ptr] <= din, wr_ptr++.
- Both accepted in one cycle: count unchanged. When full, the read frees the slot the write takes.
- Empty with ren && wen: read rejected, write accepted. No bypass; that data is readable from the next cycle.
- error <= 1 when ren && empty, or when wen && full without an accepted read. Otherwise error <= 0. A single cycle may reject one request and accept the other.
- Rejected requests never modify memory, pointers or count.
- No accepted read: valid <= 0, dout holds its last value.
- count, full and empty are registered and updated together with the pointers.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, dout=0, valid=0, error=0. Memory is not reset.
- Reset has priority over every request and discards all contents, including mid-operation.

## Timing
- Read latency is 1 cycle: ren sampled at edge N gives dout/valid after edge N.
- Status latency is 1 cycle: a write at edge N is reflected in count/empty/full after edge N, and readable at edge N+1.
- error is a one-cycle pulse per rejected cycle and is aligned with valid timing.
- Back-to-back reads and writes are sustained at full rate; no bubbles.

## Configuration
- SYNC_FIFO_ALMOST_EN defined: almost_full and almost_empty are decoded from the count register as specified above.
- SYNC_FIFO_ALMOST_EN undefined: both ports remain present and are tied to 0; the threshold comparators are not synthesised.

## Structure
- Package sync_fifo_pkg holds DEF_WIDTH=8, DEF_DEPTH=8 and the pointer-width calculation used by both modules.
- Sub-module sync_fifo_mem: DEPTH×WIDTH register file with one write port and one registered read port. The top level keeps pointers, count, flags, error and valid.

## Test plan
- After reset, ren=1 for one cycle: next cycle error=1, valid=0, dout=0x00, empty=1, count=0.
- Write 0x11..0x88 on 8 consecutive cycles: full=1 and count=8. A 9th write of 0xAA gives error=1 with count unchanged. Eight reads then return 0x11..0x88 in order with valid=1 on each, ending with empty=1.
- From full (0x11..0x88), ren=wen=1 with din=0x99: dout=0x11, error=0, count stays 8. After seven further reads, the eighth read returns 0x99.
- From empty, ren=wen=1 with din=0x5A: error=1, valid=0, count=1. A read on the next cycle returns 0x5A.
- Random mixed traffic for 40 cycles forcing at least 3 pointer wraps: every dout matches a reference queue, and every error pulse matches a model-predicted rejection.
- With count=5, assert rst_n=0 together with wen=1: next cycle count=0, empty=1, dout=0, error=0. With SYNC_FIFO_ALMOST_EN, refilling to 7 entries raises almost_full=1, and draining to 1 entry raises almost_empty=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer sizing for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // One extra pointer bit distinguishes full from empty when addresses match.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register file: one write port, one registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = ptrWidth(DEPTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wen,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ren,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read data holds between accepted reads; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_ren) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with registered status, read-valid and error strobes.
// Define SYNC_FIFO_ALMOST_EN to decode almost_full/almost_empty; otherwise both are tied low.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int PW      = ptrWidth(DEPTH),
  localparam int AW      = PW - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wen,
  input  logic             i_ren,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_error,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW-1:0]    o_count,
  output logic             o_almost_full,
  output logic             o_almost_empty
);

  localparam logic [PW-1:0] ONE_C   = PW'(1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_valid;
  logic          r_error;

  logic [PW-1:0] w_countNext;
  logic          w_rdAcc;
  logic          w_wrAcc;
  logic          w_rdRej;
  logic          w_wrRej;
  logic          w_memWen;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign w_rdAcc  = i_ren & ~r_empty;
  assign w_wrAcc  = i_wen & (~r_full | w_rdAcc);
  assign w_rdRej  = i_ren & r_empty;
  assign w_wrRej  = i_wen & r_full & ~w_rdAcc;
  assign w_memWen = w_wrAcc & rst_n;

  always_comb begin
    w_countNext = r_count;
    if (w_wrAcc && !w_rdAcc) begin
      w_countNext = r_count + ONE_C;
    end else if (w_rdAcc && !w_wrAcc) begin
      w_countNext = r_count - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + ONE_C;
      end
      if (w_rdAcc) begin
        r_rdPtr <= r_rdPtr + ONE_C;
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == DEPTH_C);
      r_empty <= (w_countNext == '0);
      r_valid <= w_rdAcc;
      r_error <= w_rdRej | w_wrRej;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wen   (w_memWen),
    .i_waddr (r_wrPtr[AW-1:0]),
    .i_wdata (i_din),
    .i_ren   (w_rdAcc),
    .i_raddr (r_rdPtr[AW-1:0]),
    .o_rdata (o_dout)
  );

  assign o_valid = r_valid;
  assign o_error = r_error;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

`ifdef SYNC_FIFO_ALMOST_EN
  localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);

  assign o_almost_full  = (r_count >= AF_C);
  assign o_almost_empty = (r_count <= AE_C);
`else
  assign o_almost_full  = 1'b0;
  assign o_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue model compared every cycle plus directed literal checks.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
`ifdef SYNC_FIFO_ALMOST_EN
  localparam logic ALMOST_ON = 1'b1;
`else
  localparam logic ALMOST_ON = 1'b0;
`endif

  logic             clk;
  logic             rstN;
  logic             wen;
  logic             ren;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             error;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             almostFull;
  logic             almostEmpty;

  int totalChecks = 0;
  int badChecks   = 0;
  int wrAccepted  = 0;

  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] expDout;
  logic             expValid;
  logic             expError;
  logic             modelReady = 1'b0;

  sync_fifo_param u_dut (
    .clk            (clk),
    .rst_n          (rstN),
    .i_wen          (wen),
    .i_ren          (ren),
    .i_din          (din),
    .o_dout         (dout),
    .o_valid        (valid),
    .o_error        (error),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count),
    .o_almost_full  (almostFull),
    .o_almost_empty (almostEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, then return just after the edge that consumed them.
  task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    rstN = r;
    wen  = w;
    ren  = rd;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference: FIFO as a queue; reads pop before writes push so full+both works.
  always @(posedge clk) begin
    logic rdOk;
    logic wrOk;
    if (!rstN) begin
      modelQ.delete();
      expDout    <= '0;
      expValid   <= 1'b0;
      expError   <= 1'b0;
      modelReady <= 1'b1;
    end else begin
      rdOk = ren && (modelQ.size() > 0);
      wrOk = wen && ((modelQ.size() < DEPTH) || rdOk);
      if (rdOk) begin
        expDout <= modelQ.pop_front();
      end
      if (wrOk) begin
        modelQ.push_back(din);
        wrAccepted++;
      end
      expValid <= rdOk;
      expError <= (ren && !rdOk) || (wen && !wrOk);
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("model.count", 32'(count), 32'(modelQ.size()));
      checkOutput("model.full", 32'(full), 32'(modelQ.size() == DEPTH));
      checkOutput("model.empty", 32'(empty), 32'(modelQ.size() == 0));
      checkOutput("model.dout", 32'(dout), 32'(expDout));
      checkOutput("model.valid", 32'(valid), 32'(expValid));
      checkOutput("model.error", 32'(error), 32'(expError));
      checkOutput("model.almost_full", 32'(almostFull), 32'(ALMOST_ON && (modelQ.size() >= DEPTH - 1)));
      checkOutput("model.almost_empty", 32'(almostEmpty), 32'(ALMOST_ON && (modelQ.size() <= 1)));
    end
  end

  initial begin
    logic [WIDTH-1:0] val;
    rstN = 1'b0;
    wen  = 1'b0;
    ren  = 1'b0;
    din  = '0;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("reset.count", 32'(count), 32'd0);
    checkOutput("reset.empty", 32'(empty), 32'd1);
    checkOutput("reset.full", 32'(full), 32'd0);
    checkOutput("reset.dout", 32'(dout), 32'h00);

    // Read while empty is rejected.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("emptyRead.error", 32'(error), 32'd1);
    checkOutput("emptyRead.valid", 32'(valid), 32'd0);
    checkOutput("emptyRead.dout", 32'(dout), 32'h00);
    checkOutput("emptyRead.count", 32'(count), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      val = 8'(i * 8'h11);
      applyStimulus(1'b1, 1'b1, 1'b0, val);
    end
    checkOutput("fill.full", 32'(full), 32'd1);
    checkOutput("fill.count", 32'(count), 32'd8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
    checkOutput("overflow.error", 32'(error), 32'd1);
    checkOutput("overflow.count", 32'(count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("drain.dout", 32'(dout), 32'(i * 8'h11));
      checkOutput("drain.valid", 32'(valid), 32'd1);
    end
    checkOutput("drain.empty", 32'(empty), 32'd1);

    // Full with simultaneous read and write.
    for (int i = 1; i <= 8; i++) begin
      val = 8'(i * 8'h11);
      applyStimulus(1'b1, 1'b1, 1'b0, val);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h99);
    checkOutput("fullBoth.dout", 32'(dout), 32'h11);
    checkOutput("fullBoth.error", 32'(error), 32'd0);
    checkOutput("fullBoth.count", 32'(count), 32'd8);
    for (int i = 2; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("fullBothDrain.dout", 32'(dout), 32'(i * 8'h11));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fullBothLast.dout", 32'(dout), 32'h99);
    checkOutput("fullBothLast.empty", 32'(empty), 32'd1);

    // Empty with simultaneous read and write: no bypass.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    checkOutput("emptyBoth.error", 32'(error), 32'd1);
    checkOutput("emptyBoth.valid", 32'(valid), 32'd0);
    checkOutput("emptyBoth.count", 32'(count), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("emptyBothRead.dout", 32'(dout), 32'h5A);
    checkOutput("emptyBothRead.valid", 32'(valid), 32'd1);

    // Mixed traffic biased towards both requests so the pointers wrap repeatedly.
    wrAccepted = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 8),
                    8'($urandom_range(0, 255)));
    end
    $display("[TB] mixed traffic accepted %0d writes", wrAccepted);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    end
    checkOutput("preReset.count", 32'(count), 32'd5);

    // Reset wins over a concurrent write.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE);
    checkOutput("midReset.count", 32'(count), 32'd0);
    checkOutput("midReset.empty", 32'(empty), 32'd1);
    checkOutput("midReset.dout", 32'(dout), 32'h00);
    checkOutput("midReset.error", 32'(error), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    end
    checkOutput("refill.count", 32'(count), 32'd7);
    checkOutput("refill.almost_full", 32'(almostFull), 32'(ALMOST_ON));
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("lowWater.count", 32'(count), 32'd1);
    checkOutput("lowWater.dout", 32'(dout), 32'h35);
    checkOutput("lowWater.almost_empty", 32'(almostEmpty), 32'(ALMOST_ON));
    checkOutput("lowWater.almost_full", 32'(almostFull), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
